// File: rtl/fp_add_seq.sv
// Multi-cycle floating-point adder/subtractor with valid/ready handshakes on both sides.
// Build option FP_ADD_RNE_EN selects round-to-nearest-even; without it results are truncated.
module fp_add_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] A,
    input  logic [EXP_W+MAN_W:0] B,
    input  logic                 op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] Result,
    output logic [3:0]           ALUFlags
);
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SIG_W = MAN_W + 5;
    localparam int XE_W  = EXP_W + 1;
    localparam logic [EXP_W-1:0] EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] FAR_SHIFT = EXP_W'(MAN_W + 3);
    localparam logic [XE_W-1:0]  XEXP_ONE  = {{(XE_W-1){1'b0}}, 1'b1};
    localparam logic [XE_W-1:0]  XEXP_MAX  = {1'b0, {EXP_W{1'b1}}};
    localparam logic [SIG_W-1:0] SIG_ONE   = {{(SIG_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Significand layout: {carry, hidden, fraction, guard, round, sticky}
    function automatic logic [SIG_W-1:0] unpack_sig(input logic [W-1:0] x);
        logic hid;
        hid = |x[W-2:MAN_W];
        return {1'b0, hid, (hid ? x[MAN_W-1:0] : {MAN_W{1'b0}}), 3'b000};
    endfunction

    state_t             state_r, state_s;
    logic [W-1:0]       a_r, b_r, spec_res_r, result_r;
    logic [3:0]         flags_r;
    logic [XE_W-1:0]    exp_r;
    logic [SIG_W-1:0]   sig_r, sml_r;
    logic               sign_r, sub_r, carry_r, zero_r, spec_r, spec_v_r;
    logic               accept_s;

    logic [EXP_W-1:0]   ea_s, eb_s, el_s, d_s;
    logic [SIG_W-1:0]   siga_s, sigb_s, sig_big_s, sig_sml_s, mask_s, sml_s, sum_s;
    logic               sign_big_s, ia_s, ib_s, spec_s, spec_v_s;
    logic [W-1:0]       spec_res_s, res_s;
    logic [SIG_W-1:0]   sig_nrm_s;
    logic [XE_W-1:0]    exp_nrm_s, exp_rnd_s;
    logic               zero_nrm_s, norm_busy_s, rinc_s, ovf_s, c_s, v_s;
    logic [MAN_W+1:0]   rnd_s;
    logic [MAN_W-1:0]   frac_rnd_s;
    logic [3:0]         flg_s;

    assign accept_s = in_valid & in_ready;
    assign Result   = result_r;
    assign ALUFlags = flags_r;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; NORM repeats while a left shift is still needed
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:  state_s = accept_s ? S_ALIGN : S_IDLE;
            S_ALIGN: state_s = S_ADD;
            S_ADD:   state_s = S_NORM;
            S_NORM:  state_s = norm_busy_s ? S_NORM : S_ROUND;
            S_ROUND: state_s = S_DONE;
            S_DONE:  state_s = out_ready ? S_IDLE : S_DONE;
            default: state_s = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        in_ready  = (state_r == S_IDLE);
        out_valid = (state_r == S_DONE);
    end

    // Operand ordering, alignment with guard/round/sticky, special-value detection
    always_comb begin
        ea_s   = a_r[W-2:MAN_W];
        eb_s   = b_r[W-2:MAN_W];
        siga_s = unpack_sig(a_r);
        sigb_s = unpack_sig(b_r);
        mask_s = {SIG_W{1'b0}};
        if ({ea_s, siga_s} >= {eb_s, sigb_s}) begin
            el_s = ea_s; d_s = ea_s - eb_s;
            sig_big_s = siga_s; sig_sml_s = sigb_s; sign_big_s = a_r[W-1];
        end else begin
            el_s = eb_s; d_s = eb_s - ea_s;
            sig_big_s = sigb_s; sig_sml_s = siga_s; sign_big_s = b_r[W-1];
        end
        if (d_s >= FAR_SHIFT) begin
            sml_s = {{(SIG_W-1){1'b0}}, |sig_sml_s};
        end else begin
            mask_s = (SIG_ONE << d_s) - SIG_ONE;
            sml_s  = (sig_sml_s >> d_s) | {{(SIG_W-1){1'b0}}, |(sig_sml_s & mask_s)};
        end
        ia_s     = (ea_s == EXP_ONES);
        ib_s     = (eb_s == EXP_ONES);
        spec_s   = ia_s | ib_s;
        spec_v_s = ia_s & ib_s & (a_r[W-1] ^ b_r[W-1]);
        if (spec_v_s) begin
            spec_res_s = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};
        end else if (ia_s) begin
            spec_res_s = {a_r[W-1], EXP_ONES, {MAN_W{1'b0}}};
        end else begin
            spec_res_s = {b_r[W-1], EXP_ONES, {MAN_W{1'b0}}};
        end
    end

    // Significand add/subtract and one normalisation step
    always_comb begin
        sum_s       = sub_r ? (sig_r - sml_r) : (sig_r + sml_r);
        sig_nrm_s   = sig_r;
        exp_nrm_s   = exp_r;
        zero_nrm_s  = zero_r;
        norm_busy_s = 1'b0;
        if (spec_r || zero_r) begin
            zero_nrm_s = zero_r;
        end else if (sig_r[SIG_W-1]) begin
            sig_nrm_s = {1'b0, sig_r[SIG_W-1:2], sig_r[1] | sig_r[0]};
            exp_nrm_s = exp_r + XEXP_ONE;
        end else if (sig_r == {SIG_W{1'b0}}) begin
            zero_nrm_s = 1'b1;
        end else if (sig_r[SIG_W-2]) begin
            zero_nrm_s = 1'b0;
        end else if (exp_r == XEXP_ONE) begin
            zero_nrm_s = 1'b1;
        end else begin
            sig_nrm_s   = {sig_r[SIG_W-2:0], 1'b0};
            exp_nrm_s   = exp_r - XEXP_ONE;
            norm_busy_s = 1'b1;
        end
    end

    // Rounding, overflow and flag generation
    always_comb begin
`ifdef FP_ADD_RNE_EN
        rinc_s = sig_r[2] & (sig_r[1] | sig_r[0] | sig_r[3]);
`else
        rinc_s = 1'b0;
`endif
        rnd_s = {1'b0, sig_r[SIG_W-2:3]} + {{(MAN_W+1){1'b0}}, rinc_s};
        if (rnd_s[MAN_W+1]) begin
            frac_rnd_s = rnd_s[MAN_W:1];
            exp_rnd_s  = exp_r + XEXP_ONE;
        end else begin
            frac_rnd_s = rnd_s[MAN_W-1:0];
            exp_rnd_s  = exp_r;
        end
        ovf_s = (exp_rnd_s >= XEXP_MAX);
        c_s   = carry_r;
        v_s   = 1'b0;
        if (spec_r) begin
            res_s = spec_res_r;
            v_s   = spec_v_r;
            c_s   = 1'b0;
        end else if (zero_r) begin
            res_s = {W{1'b0}};
        end else if (ovf_s) begin
            res_s = {sign_r, EXP_ONES, {MAN_W{1'b0}}};
            v_s   = 1'b1;
        end else begin
            res_s = {sign_r, exp_rnd_s[EXP_W-1:0], frac_rnd_s};
        end
        flg_s = {res_s[W-1], (res_s[W-2:0] == {(W-1){1'b0}}), c_s, v_s};
    end

    // Datapath registers, loaded according to the current stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_r        <= {W{1'b0}};
            b_r        <= {W{1'b0}};
            spec_res_r <= {W{1'b0}};
            result_r   <= {W{1'b0}};
            flags_r    <= 4'b0000;
            exp_r      <= {XE_W{1'b0}};
            sig_r      <= {SIG_W{1'b0}};
            sml_r      <= {SIG_W{1'b0}};
            sign_r     <= 1'b0;
            sub_r      <= 1'b0;
            carry_r    <= 1'b0;
            zero_r     <= 1'b0;
            spec_r     <= 1'b0;
            spec_v_r   <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        a_r <= A;
                        b_r <= {B[W-1] ^ op, B[W-2:0]};
                    end
                end
                S_ALIGN: begin
                    sign_r     <= sign_big_s;
                    exp_r      <= {1'b0, el_s};
                    sig_r      <= sig_big_s;
                    sml_r      <= sml_s;
                    sub_r      <= a_r[W-1] ^ b_r[W-1];
                    spec_r     <= spec_s;
                    spec_v_r   <= spec_v_s;
                    spec_res_r <= spec_res_s;
                    zero_r     <= 1'b0;
                    carry_r    <= 1'b0;
                end
                S_ADD: begin
                    sig_r   <= sum_s;
                    carry_r <= sum_s[SIG_W-1] & ~spec_r;
                end
                S_NORM: begin
                    sig_r  <= sig_nrm_s;
                    exp_r  <= exp_nrm_s;
                    zero_r <= zero_nrm_s;
                end
                S_ROUND: begin
                    result_r <= res_s;
                    flags_r  <= flg_s;
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end
endmodule
